sc_microsequencer: RTL

Microprogrammed control unit that sits directly upstream of the datapath and drives its A/B/C register addresses, mux selects, ALU operation and RD select. It reads 41-bit microwords from an external asynchronous control store and holds the current microword in the MIR. It computes the next control-store address from the COND field, a latched PSR, IR[13] and the decoded opcode. It also stalls the microprogram on memory accesses until the memory acknowledges.

---
 rtl/sc_microsequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sc_microsequencer.sv
// ============================================================================
// Module   : sc_microsequencer
// Purpose  : Microprogrammed control unit. It fetches from a combinational
//            control store, holds the MIR and computes the next address.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sc_microsequencer #(
    parameter int DATAWIDTH_MIR_DIRECTION = 6,
    parameter int DATAWIDTH_ALU_SELECTION = 4,
    parameter int DATAWIDTH_DECODEROP     = 8,
    parameter int DATAWIDTH_CS_ADDRESS    = 11,
    parameter int DATAWIDTH_MICROWORD     = 41
) (
    input  logic                                uSEQ_CLOCK_50,
    input  logic                                uSEQ_ResetInHigh_In,
    input  logic [DATAWIDTH_MICROWORD-1:0]      uSEQ_MicroWord_InBus,
    input  logic [DATAWIDTH_DECODEROP-1:0]      uSEQ_DecodeOP_InBus,
    input  logic                                uSEQ_IR13_In,
    input  logic                                uSEQ_FlagNegative_In,
    input  logic                                uSEQ_FlagZero_In,
    input  logic                                uSEQ_FlagOverflow_In,
    input  logic                                uSEQ_FlagCarry_In,
    input  logic                                uSEQ_MemReady_In,
    output logic [DATAWIDTH_CS_ADDRESS-1:0]     uSEQ_CSAddress_OutBus,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]  uSEQ_DirA_OutBus,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]  uSEQ_DirB_OutBus,
    output logic [DATAWIDTH_MIR_DIRECTION-1:0]  uSEQ_DirC_OutBus,
    output logic                                uSEQ_SelectA_Out,
    output logic                                uSEQ_SelectB_Out,
    output logic                                uSEQ_SelectC_Out,
    output logic                                uSEQ_RD_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]  uSEQ_ALUOperation_OutBus,
    output logic                                uSEQ_MemRead_Out,
    output logic                                uSEQ_MemWrite_Out,
    output logic                                uSEQ_Stall_Out,
    output logic [3:0]                          uSEQ_PSR_OutBus
);

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                             state_q;
    logic [DATAWIDTH_CS_ADDRESS-1:0]    csai_q;
    logic [DATAWIDTH_MICROWORD-1:0]     mir_q;
    logic [3:0]                         psr_q;

    logic [DATAWIDTH_CS_ADDRESS-1:0]    csai_d;
    logic [DATAWIDTH_CS_ADDRESS-1:0]    seq_addr;
    logic [DATAWIDTH_CS_ADDRESS-1:0]    branch_addr;
    logic                               stall;
    logic                               cc_op;

    logic                               rst;
    logic                               clk;
    assign rst = uSEQ_ResetInHigh_In;
    assign clk = uSEQ_CLOCK_50;

    logic                               f_rd;
    logic                               f_wr;
    logic [3:0]                         f_alu;
    logic [2:0]                         f_cond;
    logic [10:0]                        f_jaddr;

    assign f_rd    = mir_q[19];
    assign f_wr    = mir_q[18];
    assign f_alu   = mir_q[17:14];
    assign f_cond  = mir_q[13:11];
    assign f_jaddr = mir_q[10:0];

    assign uSEQ_DirA_OutBus         = mir_q[40:35];
    assign uSEQ_SelectA_Out         = mir_q[34];
    assign uSEQ_DirB_OutBus         = mir_q[33:28];
    assign uSEQ_SelectB_Out         = mir_q[27];
    assign uSEQ_SelectC_Out         = mir_q[20];
    assign uSEQ_RD_Out              = f_rd;
    assign uSEQ_ALUOperation_OutBus = f_alu;
    assign uSEQ_MemRead_Out         = f_rd;
    assign uSEQ_MemWrite_Out        = f_wr & ~f_rd;
    assign uSEQ_PSR_OutBus          = psr_q;

    // A stalled cycle redirects the C write to r0 so the datapath result is discarded.
    assign stall = ~rst & (state_q != S_RESET) & (f_rd | f_wr) & ~uSEQ_MemReady_In;
    assign uSEQ_Stall_Out   = stall;
    assign uSEQ_DirC_OutBus = stall ? '0 : mir_q[26:21];

    assign cc_op    = (f_alu[3:2] == 2'b00);
    assign seq_addr = csai_q + 1'b1;

    always_comb begin
        branch_addr = seq_addr;
        case (f_cond)
            3'b001:  if (psr_q[3])     branch_addr = f_jaddr;
            3'b010:  if (psr_q[2])     branch_addr = f_jaddr;
            3'b011:  if (psr_q[1])     branch_addr = f_jaddr;
            3'b100:  if (psr_q[0])     branch_addr = f_jaddr;
            3'b101:  if (uSEQ_IR13_In) branch_addr = f_jaddr;
            3'b110:  branch_addr = f_jaddr;
            3'b111:  branch_addr = {1'b1, uSEQ_DecodeOP_InBus, 2'b00};
            default: branch_addr = seq_addr;
        endcase
    end

    always_comb begin
        csai_d = branch_addr;
        if (rst || state_q == S_RESET) begin
            csai_d = '0;
        end else if (stall) begin
            csai_d = csai_q;
        end
    end

    assign uSEQ_CSAddress_OutBus = csai_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            csai_q  <= '0;
            mir_q   <= '0;
            psr_q   <= '0;
        end else begin
            case (state_q)
                S_RESET: begin
                    mir_q   <= uSEQ_MicroWord_InBus;
                    csai_q  <= '0;
                    state_q <= S_RUN;
                end
                default: begin
                    if (stall) begin
                        state_q <= S_WAIT;
                    end else begin
                        mir_q   <= uSEQ_MicroWord_InBus;
                        csai_q  <= csai_d;
                        state_q <= S_RUN;
                        if (cc_op) begin
                            psr_q <= {uSEQ_FlagNegative_In, uSEQ_FlagZero_In,
                                      uSEQ_FlagOverflow_In, uSEQ_FlagCarry_In};
                        end
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire
